// File: rtl/data_mem_ctrl.sv
// Data memory controller: serialises byte/half/word loads and stores onto an
// 8-bit RAM port, little-endian, with IO write-buffer back-pressure.
module data_mem_ctrl (
   input  logic        clockIn,
   input  logic        resetIn,
   input  logic        clearIn,
   input  logic [1:0]  accessType,
   input  logic        readWriteIn,
   input  logic [31:0] dataAddr,
   input  logic [31:0] dataIn,
   output logic        dataValid,
   output logic [31:0] dataOut,
   output logic        dataWriteSuc,
   output logic        busy,
   input  logic [7:0]  memIn,
   output logic [7:0]  memOut,
   output logic [31:0] memAddr,
   output logic        memWrite,
   input  logic        ioBufferFull,
   output logic [1:0]  stateDbg
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;

   // Handshake: a request is a one-cycle accessType != 0 sampled in IDLE;
   // completion is a one-cycle dataValid (read) or dataWriteSuc (write) pulse.
   stateT       state, stateNext;
   logic [2:0]  byteCnt;
   logic [1:0]  lastIdx;
   logic        isRead;
   logic [31:0] wrData;
   logic [31:0] rdBuf;
   logic [31:0] rdMerged;
   logic [1:0]  capIdx;
   logic [7:0]  wrByte;
   logic        ioStall;
   logic        issue;

   assign ioStall      = (memAddr[17:16] == 2'b11) && ioBufferFull;
   assign issue        = (state == WRITE) && !ioStall;
   assign memWrite     = issue;
   assign memOut       = issue ? wrByte : 8'h00;
   assign dataValid    = (state == DONE) && isRead;
   assign dataWriteSuc = (state == DONE) && !isRead;
   assign busy         = (state != IDLE);
   assign stateDbg     = state;
   assign capIdx       = 2'(byteCnt - 3'd1);

   always_comb begin
      wrByte = wrData[7:0];
      case (byteCnt[1:0])
         2'd0: wrByte = wrData[7:0];
         2'd1: wrByte = wrData[15:8];
         2'd2: wrByte = wrData[23:16];
         2'd3: wrByte = wrData[31:24];
         default: wrByte = wrData[7:0];
      endcase
   end

   // Byte addressed in the previous cycle arrives now; slot it in place.
   always_comb begin
      rdMerged = rdBuf;
      case (capIdx)
         2'd0: rdMerged[7:0]   = memIn;
         2'd1: rdMerged[15:8]  = memIn;
         2'd2: rdMerged[23:16] = memIn;
         2'd3: rdMerged[31:24] = memIn;
         default: rdMerged = rdBuf;
      endcase
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (accessType != 2'b00) begin
               if (!readWriteIn)  stateNext = WRITE;
               else if (!clearIn) stateNext = READ;
            end
         end
         READ: begin
            if (clearIn)                              stateNext = IDLE;
            else if (byteCnt == {1'b0, lastIdx} + 3'd1) stateNext = DONE;
         end
         WRITE: begin
            if (issue && (byteCnt[1:0] == lastIdx)) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         state   <= IDLE;
         memAddr <= 32'h0;
         byteCnt <= 3'd0;
         lastIdx <= 2'd0;
         isRead  <= 1'b0;
         wrData  <= 32'h0;
         rdBuf   <= 32'h0;
         dataOut <= 32'h0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (stateNext != IDLE) begin
                  memAddr <= dataAddr;
                  byteCnt <= 3'd0;
                  lastIdx <= {accessType[1] & accessType[0], accessType[1]};
                  isRead  <= readWriteIn;
                  wrData  <= dataIn;
                  rdBuf   <= 32'h0;
               end
            end
            READ: begin
               if (!clearIn) begin
                  byteCnt <= byteCnt + 3'd1;
                  if (byteCnt < {1'b0, lastIdx}) memAddr <= memAddr + 32'd1;
                  if (byteCnt != 3'd0)           rdBuf   <= rdMerged;
                  if (stateNext == DONE)         dataOut <= rdMerged;
               end
            end
            WRITE: begin
               if (issue && (stateNext != DONE)) begin
                  byteCnt <= byteCnt + 3'd1;
                  memAddr <= memAddr + 32'd1;
               end
            end
            DONE:    byteCnt <= 3'd0;
            default: byteCnt <= 3'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: request table with per-cycle checks of the
// RAM port, plus hand-written reset and mid-write reset sequences.
module tb_data_mem_ctrl;

   logic        clockIn = 1'b0;
   logic        resetIn;
   logic        clearIn;
   logic [1:0]  accessType;
   logic        readWriteIn;
   logic [31:0] dataAddr;
   logic [31:0] dataIn;
   logic        dataValid;
   logic [31:0] dataOut;
   logic        dataWriteSuc;
   logic        busy;
   logic [7:0]  memIn;
   logic [7:0]  memOut;
   logic [31:0] memAddr;
   logic        memWrite;
   logic        ioBufferFull;
   logic [1:0]  stateDbg;

   int nChecks = 0;
   int nFail   = 0;
   logic [39:0] expQ[$];

   typedef struct {
      logic [1:0]  acc;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] din;
      int          ioFull;
      int          clearCyc;
      logic [31:0] expOut;
      int          expDone;
      int          expIdle;
   } vecT;

   vecT vecs[13];

   data_mem_ctrl dut (
      .clockIn(clockIn), .resetIn(resetIn), .clearIn(clearIn),
      .accessType(accessType), .readWriteIn(readWriteIn),
      .dataAddr(dataAddr), .dataIn(dataIn),
      .dataValid(dataValid), .dataOut(dataOut),
      .dataWriteSuc(dataWriteSuc), .busy(busy),
      .memIn(memIn), .memOut(memOut), .memAddr(memAddr),
      .memWrite(memWrite), .ioBufferFull(ioBufferFull), .stateDbg(stateDbg)
   );

   always #5 clockIn = ~clockIn;

   function automatic logic [7:0] ramByte(input logic [31:0] a);
      logic [7:0] base;
      case (a[1:0])
         2'd0: base = 8'h11;
         2'd1: base = 8'h22;
         2'd2: base = 8'h33;
         default: base = 8'h44;
      endcase
      return base ^ {a[7:4], 4'h0};
   endfunction

   // Synchronous RAM: byte for the address presented now appears next cycle.
   always @(posedge clockIn) memIn <= ramByte(memAddr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic runVec(input int idx, input vecT v);
      int n, effStall, doneCyc, pulses, idleCyc;
      logic expWr;
      logic [31:0] tmp;
      logic [39:0] e;
      n = (v.acc == 2'b11) ? 4 : (v.acc == 2'b10) ? 2 : 1;
      effStall = (v.addr[17:16] == 2'b11) ? v.ioFull : 0;
      if (!v.rw) begin
         for (int k = 0; k < n; k++) begin
            tmp = v.din >> (8 * k);
            expQ.push_back({v.addr + 32'(k), tmp[7:0]});
         end
      end
      @(posedge clockIn); #1;
      accessType  = v.acc;
      readWriteIn = v.rw;
      dataAddr    = v.addr;
      dataIn      = v.din;
      clearIn     = (v.clearCyc == 0);
      @(posedge clockIn); #1;
      accessType = 2'b00;
      dataAddr   = $urandom;
      dataIn     = $urandom;
      doneCyc = 0; pulses = 0; idleCyc = -1;
      for (int c = 1; c <= 30; c++) begin
         ioBufferFull = (c <= v.ioFull);
         clearIn      = (c == v.clearCyc);
         @(negedge clockIn);
         expWr = !v.rw && (c > effStall) && (c <= effStall + n);
         check($sformatf("v%0d memWrite c%0d", idx, c), {31'h0, memWrite}, {31'h0, expWr});
         if (memWrite && expWr) begin
            if (expQ.size() == 0) begin
               nChecks++; nFail++;
               $display("FAIL v%0d unexpected write c%0d: got %h expected none", idx, c, memAddr);
            end else begin
               e = expQ.pop_front();
               check($sformatf("v%0d wr addr c%0d", idx, c), memAddr, e[39:8]);
               check($sformatf("v%0d wr data c%0d", idx, c), {24'h0, memOut}, {24'h0, e[7:0]});
            end
         end else if (!memWrite) begin
            check($sformatf("v%0d memOut idle c%0d", idx, c), {24'h0, memOut}, 32'h0);
         end
         if (v.rw && v.clearCyc != 0 && c <= n && (v.clearCyc < 0 || c <= v.clearCyc))
            check($sformatf("v%0d rd addr c%0d", idx, c), memAddr, v.addr + 32'(c - 1));
         if (dataValid && dataWriteSuc) begin
            nChecks++; nFail++;
            $display("FAIL v%0d pulse overlap c%0d: got both expected one", idx, c);
         end
         if (dataValid || dataWriteSuc) begin
            pulses++;
            doneCyc = c;
            check($sformatf("v%0d pulse kind", idx), {31'h0, dataValid}, {31'h0, v.rw});
         end
         if (!busy) begin
            idleCyc = c;
            break;
         end
         @(posedge clockIn); #1;
      end
      ioBufferFull = 1'b0;
      clearIn      = 1'b0;
      check($sformatf("v%0d pulse count", idx), 32'(pulses), (v.expDone > 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d done cycle", idx), 32'(doneCyc), 32'(v.expDone));
      check($sformatf("v%0d idle cycle", idx), 32'(idleCyc), 32'(v.expIdle));
      check($sformatf("v%0d dataOut", idx), dataOut, v.expOut);
      check($sformatf("v%0d bytes left", idx), 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   initial begin
      resetIn = 1'b1; clearIn = 1'b0; accessType = 2'b00; readWriteIn = 1'b0;
      dataAddr = 32'h0; dataIn = 32'h0; ioBufferFull = 1'b0;

      //          acc    rw    addr          din           io clr  expOut        done idle
      vecs[0]  = '{2'b11, 1'b1, 32'h00001000, 32'h0,        0, -1, 32'h44332211, 6, 7};
      vecs[1]  = '{2'b10, 1'b0, 32'h00000202, 32'h0000BEEF, 0, -1, 32'h44332211, 3, 4};
      vecs[2]  = '{2'b01, 1'b0, 32'h00030000, 32'h000000AB, 3, -1, 32'h44332211, 5, 6};
      vecs[3]  = '{2'b11, 1'b1, 32'h00000100, 32'h0,        0,  2, 32'h44332211, 0, 3};
      vecs[4]  = '{2'b01, 1'b1, 32'h00000053, 32'h0,        0, -1, 32'h00000014, 3, 4};
      vecs[5]  = '{2'b11, 1'b0, 32'hFFFFFFFE, 32'h12345678, 0, -1, 32'h00000014, 5, 6};
      vecs[6]  = '{2'b10, 1'b1, 32'h0000020F, 32'h0,        0, -1, 32'h00000144, 4, 5};
      vecs[7]  = '{2'b10, 1'b0, 32'h00000400, 32'h0000CAFE, 0,  1, 32'h00000144, 3, 4};
      vecs[8]  = '{2'b11, 1'b1, 32'h00001000, 32'h0,        0,  0, 32'h00000144, 0, 1};
      vecs[9]  = '{2'b01, 1'b0, 32'h00000010, 32'h00000077, 0,  0, 32'h00000144, 2, 3};
      vecs[10] = '{2'b11, 1'b1, 32'h00001000, 32'h0,        5, -1, 32'h44332211, 6, 7};
      vecs[11] = '{2'b01, 1'b0, 32'h00020000, 32'h000000C3, 2, -1, 32'h44332211, 2, 3};
      vecs[12] = '{2'b01, 1'b0, 32'h00038000, 32'h0000005A, 0,  2, 32'h44332211, 2, 3};

      #23;
      check("rst memWrite", {31'h0, memWrite}, 32'h0);
      check("rst memOut", {24'h0, memOut}, 32'h0);
      check("rst memAddr", memAddr, 32'h0);
      check("rst dataOut", dataOut, 32'h0);
      check("rst dataValid", {31'h0, dataValid}, 32'h0);
      check("rst dataWriteSuc", {31'h0, dataWriteSuc}, 32'h0);
      check("rst busy", {31'h0, busy}, 32'h0);
      check("rst state", {30'h0, stateDbg}, 32'h0);
      @(negedge clockIn);
      resetIn = 1'b0;

      for (int i = 0; i < 13; i++) runVec(i, vecs[i]);

      // Reset asserted mid-cycle during C2 of a word write.
      @(posedge clockIn); #1;
      accessType = 2'b11; readWriteIn = 1'b0; dataAddr = 32'h00005000; dataIn = 32'hA1B2C3D4;
      @(posedge clockIn); #1;
      accessType = 2'b00;
      @(posedge clockIn); #2;
      check("midrst C2 write active", {31'h0, memWrite}, 32'h1);
      check("midrst C2 addr", memAddr, 32'h00005001);
      resetIn = 1'b1;
      #1;
      check("midrst memWrite", {31'h0, memWrite}, 32'h0);
      check("midrst busy", {31'h0, busy}, 32'h0);
      check("midrst memAddr", memAddr, 32'h0);
      check("midrst memOut", {24'h0, memOut}, 32'h0);
      @(posedge clockIn); #1;
      resetIn = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clockIn);
         check($sformatf("midrst no suc c%0d", c), {31'h0, dataWriteSuc}, 32'h0);
         check($sformatf("midrst idle c%0d", c), {31'h0, busy}, 32'h0);
      end

      // Controller still serves requests after the abandoned write.
      runVec(13, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
